// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweep stages.
// Holds the sweep FSM state encoding, the row-count helper and the legal parameter ranges.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int N_IN_MIN   = 32'sd1;
    localparam int N_IN_MAX   = 32'sd4;
    localparam int SETTLE_MIN = 32'sd1;
    localparam int SETTLE_MAX = 32'sd15;

    // Number of truth-table rows for an n_in-input function.
    function automatic int rows_f(input int n_in);
        rows_f = 32'sd1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bus between the sweeper and its function under test / controller.
// With TRUTH_TABLE_SWEEPER_CHECK_EN defined, the golden table and mismatch flag are added.
interface truth_table_sweeper_if
    import sweeper_pkg::*;
#(
    parameter int N_IN = 3
);
    localparam int ROWS = rows_f(N_IN);

    logic            start;
    logic            s_in;
    logic [N_IN-1:0] abc_out;
    logic [N_IN-1:0] m_out;
    logic [ROWS-1:0] table_out;
    logic            busy;
    logic            done;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    logic [ROWS-1:0] expect_in;
    logic            mismatch;

    modport master (
        output start, s_in, expect_in,
        input  abc_out, m_out, table_out, busy, done, mismatch
    );
    modport slave (
        input  start, s_in, expect_in,
        output abc_out, m_out, table_out, busy, done, mismatch
    );
`else
    modport master (
        output start, s_in,
        input  abc_out, m_out, table_out, busy, done
    );
    modport slave (
        input  start, s_in,
        output abc_out, m_out, table_out, busy, done
    );
`endif

endinterface

// File: rtl/truth_table_sweeper_settle_timer.sv
// settle_timer: loadable 4-bit down-counter with a zero flag.
// Decrement saturates at zero so a stray dec never wraps to 15.
module settle_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] load_val,
    output logic       zero
);
    logic [3:0] count_r;

    // Counter register: load wins over decrement.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != 4'd0)) begin
            count_r <= count_r - 4'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == 4'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every minterm of an N_IN-input function, captures its output.
// Optional golden-table compare when TRUTH_TABLE_SWEEPER_CHECK_EN is defined.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input logic                  clk,
    input logic                  reset,
    truth_table_sweeper_if.slave bus
);
    localparam int              ROWS        = rows_f(N_IN);
    localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] IDX_LAST    = N_IN'(ROWS - 1);
    localparam logic [N_IN-1:0] IDX_ONE     = N_IN'(1'b1);
    // The SETTLE parameter hides the enum literal of the same name.
    localparam state_t          ST_SETTLE   = sweeper_pkg::SETTLE;

    state_t          state_r, state_s;
    logic [N_IN-1:0] idx_r, idx_s;
    logic [ROWS-1:0] table_r, table_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            tmr_load_s, tmr_dec_s, tmr_zero_s;
    logic            accept_s;
    logic            last_sample_s;

    settle_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .dec      (tmr_dec_s),
        .load_val (SETTLE_LOAD),
        .zero     (tmr_zero_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is honoured only while not sweeping.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) state_s = ST_SETTLE;
                else           state_s = state_r;
            end
            ST_SETTLE: begin
                if (tmr_zero_s) state_s = SAMPLE;
                else            state_s = ST_SETTLE;
            end
            SAMPLE: begin
                if (idx_r == IDX_LAST) state_s = DONE;
                else                   state_s = ST_SETTLE;
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and output next values derived from the current state.
    always_comb begin
        idx_s         = idx_r;
        table_s       = table_r;
        tmr_load_s    = 1'b0;
        tmr_dec_s     = 1'b0;
        accept_s      = 1'b0;
        last_sample_s = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept_s   = 1'b1;
                    idx_s      = {N_IN{1'b0}};
                    table_s    = {ROWS{1'b0}};
                    tmr_load_s = 1'b1;
                end else begin
                    accept_s   = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (tmr_zero_s) tmr_dec_s = 1'b0;
                else            tmr_dec_s = 1'b1;
            end
            SAMPLE: begin
                table_s[idx_r] = bus.s_in;
                if (idx_r == IDX_LAST) begin
                    last_sample_s = 1'b1;
                end else begin
                    idx_s      = idx_r + IDX_ONE;
                    tmr_load_s = 1'b1;
                end
            end
            default: begin
                idx_s   = {N_IN{1'b0}};
                table_s = {ROWS{1'b0}};
            end
        endcase
        busy_s = (state_s == ST_SETTLE) || (state_s == SAMPLE);
        done_s = (state_s == DONE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_r   <= {N_IN{1'b0}};
            table_r <= {ROWS{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            idx_r   <= idx_s;
            table_r <= table_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign bus.abc_out   = idx_r;
    assign bus.m_out     = idx_r;
    assign bus.table_out = table_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    logic [ROWS-1:0] expect_r;
    logic            mismatch_r, mismatch_s;

    // Mismatch is judged on the final table, so it is valid as done rises.
    always_comb begin
        mismatch_s = mismatch_r;
        if (accept_s) begin
            mismatch_s = 1'b0;
        end else if (last_sample_s) begin
            mismatch_s = (table_s != expect_r);
        end else begin
            mismatch_s = mismatch_r;
        end
    end

    // Golden table latch and mismatch flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            expect_r   <= {ROWS{1'b0}};
            mismatch_r <= 1'b0;
        end else begin
            expect_r   <= accept_s ? bus.expect_in : expect_r;
            mismatch_r <= mismatch_s;
        end
    end

    assign bus.mismatch = mismatch_r;
`else
    logic unused_s;
    assign unused_s = accept_s ^ last_sample_s;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: default 3-input AND-OR sweep and a 2-input XOR sweep.
// Golden tables come from a bench-side model of each function and flow through a scoreboard queue.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    logic reset;
    logic s_mode;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    truth_table_sweeper_if #(.N_IN(3)) if3 ();
    truth_table_sweeper_if #(.N_IN(2)) if2 ();

    assign if3.s_in = s_mode ? 1'b1
                    : ((if3.abc_out[2] & if3.abc_out[1]) | (if3.abc_out[2] & if3.abc_out[0]));
    assign if2.s_in = if2.abc_out[1] ^ if2.abc_out[0];

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
    truth_table_sweeper #(.N_IN(2), .SETTLE(3)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model3(input logic tie);
        logic [7:0] t;
        logic [2:0] v;
        t = 8'h00;
        for (int k = 0; k < 8; k++) begin
            v = 3'(k);
            t[k] = tie | ((v[2] & v[1]) | (v[2] & v[0]));
        end
        return t;
    endfunction

    function automatic logic [3:0] model2();
        logic [3:0] t;
        logic [1:0] v;
        t = 4'h0;
        for (int k = 0; k < 4; k++) begin
            v = 2'(k);
            t[k] = v[1] ^ v[0];
        end
        return t;
    endfunction

    // Runs one sweep on the 3-input DUT; pulse_at >= 0 injects a start pulse mid-sweep.
    task automatic run_sweep3(input int pulse_at, input logic [7:0] exp_tbl, input bit check_m);
        int cycles;
        logic [15:0] exp_v;
        exp_q.push_back({8'h00, exp_tbl});
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        n_tests++;
        if (if3.busy !== 1'b1 || if3.done !== 1'b0 || if3.table_out !== 8'h00 || if3.m_out !== 3'd0) begin
            n_fail++;
            $display("FAIL start_edge: busy=%b done=%b table=%h m=%0d, need busy=1 done=0 table=00 m=0",
                     if3.busy, if3.done, if3.table_out, if3.m_out);
        end
        cycles = 0;
        while (if3.done !== 1'b1 && cycles < 40) begin
            if (check_m) begin
                n_tests++;
                if (if3.m_out !== 3'(cycles / 2) || if3.abc_out !== if3.m_out) begin
                    n_fail++;
                    $display("FAIL m_step c%0d: m=%0d abc=%0d, need %0d", cycles, if3.m_out, if3.abc_out, cycles / 2);
                end
            end
            if3.start = (cycles == pulse_at);
            tick();
            if3.start = 1'b0;
            cycles++;
        end
        n_tests++;
        if (cycles != 16) begin
            n_fail++;
            $display("FAIL latency3: done after %0d cycles, need 16", cycles);
        end
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({8'h00, if3.table_out} !== exp_v || if3.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL table3: table=%h busy=%b, need table=%h busy=0", if3.table_out, if3.busy, exp_v[7:0]);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        n_tests++;
        if (if3.abc_out !== 3'd0 || if3.m_out !== 3'd0 || if3.table_out !== 8'h00 ||
            if3.busy !== 1'b0 || if3.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset3: abc=%0d m=%0d table=%h busy=%b done=%b, need all 0",
                     if3.abc_out, if3.m_out, if3.table_out, if3.busy, if3.done);
        end
        n_tests++;
        if (if2.table_out !== 4'h0 || if2.busy !== 1'b0 || if2.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset2: table=%h busy=%b done=%b, need all 0", if2.table_out, if2.busy, if2.done);
        end
    endtask

    task automatic test_basic_sweep;
        s_mode = 1'b0;
        run_sweep3(-1, model3(1'b0), 1'b1);
    endtask

    task automatic test_reset_mid_sweep;
        s_mode = 1'b1;
        if3.start = 1'b1;
        tick();
        if3.start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        n_tests++;
        if (if3.m_out !== 3'd4 || if3.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_idx: m=%0d busy=%b, need m=4 busy=1", if3.m_out, if3.busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (if3.table_out !== 8'h00 || if3.abc_out !== 3'd0 || if3.busy !== 1'b0 || if3.done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: table=%h abc=%0d busy=%b done=%b, need 00/0/0/0",
                     if3.table_out, if3.abc_out, if3.busy, if3.done);
        end
        tick();
        s_mode = 1'b0;
        run_sweep3(-1, model3(1'b0), 1'b0);
    endtask

    task automatic test_start_ignored;
        s_mode = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_sweep3(4, model3(1'b0), 1'b1);
    endtask

    task automatic test_restart_from_done;
        n_tests++;
        if (if3.done !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_restart: done=%b, need 1", if3.done);
        end
        s_mode = 1'b1;
        run_sweep3(-1, model3(1'b1), 1'b0);
        s_mode = 1'b0;
    endtask

    task automatic test_settle3_two_input;
        int cycles;
        logic [15:0] exp_v;
        exp_q.push_back({12'h000, model2()});
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        cycles = 0;
        while (if2.done !== 1'b1 && cycles < 60) begin
            n_tests++;
            if (if2.m_out !== 2'(cycles / 4)) begin
                n_fail++;
                $display("FAIL m2_step c%0d: m=%0d, need %0d", cycles, if2.m_out, cycles / 4);
            end
            tick();
            cycles++;
        end
        n_tests++;
        if (cycles != 16) begin
            n_fail++;
            $display("FAIL latency2: done after %0d cycles, need 16", cycles);
        end
        exp_v = exp_q.pop_front();
        n_tests++;
        if ({12'h000, if2.table_out} !== exp_v) begin
            n_fail++;
            $display("FAIL table2: table=%b, need %b", if2.table_out, exp_v[3:0]);
        end
    endtask

`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
    task automatic test_check;
        s_mode = 1'b0;
        if3.expect_in = 8'hE0;
        run_sweep3(-1, model3(1'b0), 1'b0);
        n_tests++;
        if (if3.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL match: mismatch=%b, need 0", if3.mismatch);
        end
        if3.expect_in = 8'hE1;
        run_sweep3(-1, model3(1'b0), 1'b0);
        n_tests++;
        if (if3.mismatch !== 1'b1) begin
            n_fail++;
            $display("FAIL mismatch: mismatch=%b, need 1", if3.mismatch);
        end
        if3.expect_in = 8'hE0;
        run_sweep3(-1, model3(1'b0), 1'b0);
        n_tests++;
        if (if3.mismatch !== 1'b0) begin
            n_fail++;
            $display("FAIL mismatch_clear: mismatch=%b, need 0", if3.mismatch);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        s_mode    = 1'b0;
        if3.start = 1'b0;
        if2.start = 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        if3.expect_in = 8'h00;
        if2.expect_in = 4'h0;
`endif
        test_reset();
        test_basic_sweep();
        test_reset_mid_sweep();
        test_start_ignored();
        test_restart_from_done();
        test_settle3_two_input();
`ifdef TRUTH_TABLE_SWEEPER_CHECK_EN
        test_check();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
